// File: rtl/game_pkg.sv
// Shared definitions for the game blocks.
//   state_e    : match timer FSM states
//   SEG_DASH   : active-low pattern with only segment g lit
//   SEG_BLANK  : all segments off
//   SEG_D0..9  : active-low digit patterns, bit 6 = g ... bit 0 = a
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_D0    = 7'h40;
  localparam logic [6:0] SEG_D1    = 7'h79;
  localparam logic [6:0] SEG_D2    = 7'h24;
  localparam logic [6:0] SEG_D3    = 7'h30;
  localparam logic [6:0] SEG_D4    = 7'h19;
  localparam logic [6:0] SEG_D5    = 7'h12;
  localparam logic [6:0] SEG_D6    = 7'h02;
  localparam logic [6:0] SEG_D7    = 7'h78;
  localparam logic [6:0] SEG_D8    = 7'h00;
  localparam logic [6:0] SEG_D9    = 7'h10;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern.
//   bcd : 4-bit digit, values above 9 produce a blank digit
//   seg : active-low segments, seg[6] = g, seg[0] = a
module seg7_decode
  import game_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_D0;
      4'd1: seg = SEG_D1;
      4'd2: seg = SEG_D2;
      4'd3: seg = SEG_D3;
      4'd4: seg = SEG_D4;
      4'd5: seg = SEG_D5;
      4'd6: seg = SEG_D6;
      4'd7: seg = SEG_D7;
      4'd8: seg = SEG_D8;
      4'd9: seg = SEG_D9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/match_timer.sv
// Match countdown timer with mm:ss on a multiplexed 4-digit display.
// All timing comes from clock enables derived from `clock`.
//   clock, reset  : board clock, synchronous active-high reset
//   start         : level from the menu, high while a match is on
//   player        : 0 = player 1, 1 = player 2 (left dot in IDLE)
//   pause         : level, freezes the countdown
//   seg, an, dp   : active-low segments / digit enables / decimal point
//   time_left     : remaining seconds
//   running       : high in RUNNING only
//   expired       : high in EXPIRED
//   expire_pulse  : single cycle on entry to EXPIRED
module match_timer
  import game_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int MATCH_SECONDS = 120,
  parameter int REFRESH_DIV   = 250_000,
  parameter int FLASH_SECONDS = 10,
  parameter int BLINK_DIV     = 50_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        player,
  input  logic        pause,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic [12:0] time_left,
  output logic        running,
  output logic        expired,
  output logic        expire_pulse
);

  localparam int PRE_W = $clog2(CLK_HZ + 1);
  localparam int REF_W = $clog2(REFRESH_DIV + 1);
  localparam int BLK_W = $clog2(BLINK_DIV + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
  localparam logic [12:0]      MATCH_TL = 13'(MATCH_SECONDS);
  localparam logic [12:0]      FLASH_TL = 13'(FLASH_SECONDS);

  state_e             state_q, state_d;
  logic [12:0]        tl_q, tl_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [REF_W-1:0]   ref_q, ref_d;
  logic [1:0]         scan_q, scan_d;
  logic               scan_on_q, scan_on_d;
  logic [BLK_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic               blink_q, blink_d;
  logic [6:0]         seg_q, seg_d;
  logic [3:0]         an_q, an_d;
  logic               dp_q, dp_d;
  logic               pulse_q, pulse_d;

  logic [12:0]        mins, secs;
  logic [3:0]         dig_bcd;
  logic [6:0]         dig_seg;
  logic               flash;

  // Match FSM and countdown. start=0 wins over everything, then pause, then tick.
  always_comb begin
    state_d = state_q;
    tl_d    = tl_q;
    pre_d   = pre_q;
    if (!start) begin
      state_d = ST_IDLE;
      tl_d    = MATCH_TL;
      pre_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tl_d  = MATCH_TL;
          pre_d = '0;
          if (MATCH_SECONDS == 0) state_d = ST_EXPIRED;
          else if (pause)         state_d = ST_PAUSED;
          else                    state_d = ST_RUNNING;
        end
        ST_RUNNING: begin
          // Pausing leaves the prescaler untouched so a partial second resumes.
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (tl_q <= 13'd1) begin
              tl_d    = '0;
              state_d = ST_EXPIRED;
            end else begin
              tl_d = tl_q - 13'd1;
            end
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        ST_PAUSED: if (!pause) state_d = ST_RUNNING;
        default: ;
      endcase
    end
    pulse_d = (state_d == ST_EXPIRED) && (state_q != ST_EXPIRED);
  end

  // Digit scan and blink phase run in every state.
  always_comb begin
    ref_d     = (ref_q == REF_LAST) ? '0 : ref_q + 1'b1;
    scan_on_d = scan_on_q | (ref_q == REF_LAST);
    scan_d    = scan_q;
    if (ref_q == REF_LAST) scan_d = scan_on_q ? scan_q + 2'd1 : 2'd0;
    blk_cnt_d = (blk_cnt_q == BLK_LAST) ? '0 : blk_cnt_q + 1'b1;
    blink_d   = blink_q ^ (blk_cnt_q == BLK_LAST);
  end

  always_comb begin
    mins = tl_q / 13'd60;
    secs = tl_q % 13'd60;
    case (scan_d)
      2'd0:    dig_bcd = 4'(secs % 13'd10);
      2'd1:    dig_bcd = 4'(secs / 13'd10);
      2'd2:    dig_bcd = 4'(mins % 13'd10);
      default: dig_bcd = 4'(mins / 13'd10);
    endcase
  end

  seg7_decode u_dec (
    .bcd (dig_bcd),
    .seg (dig_seg)
  );

  // Display registers follow the scan index chosen on this same edge.
  always_comb begin
    flash = (state_q == ST_RUNNING) && (tl_q != '0) && (tl_q <= FLASH_TL) && blink_q;
    an_d  = scan_on_d ? ~(4'b0001 << scan_d) : 4'b1111;
    if (state_q == ST_IDLE) begin
      seg_d = SEG_DASH;
      dp_d  = !(player && (scan_d == 2'd3));
    end else begin
      seg_d = dig_seg;
      dp_d  = !(scan_d == 2'd2);   // colon between minutes and seconds
    end
    if (flash || !scan_on_d) begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tl_q      <= MATCH_TL;
      pre_q     <= '0;
      ref_q     <= '0;
      scan_q    <= '0;
      scan_on_q <= 1'b0;
      blk_cnt_q <= '0;
      blink_q   <= 1'b0;
      seg_q     <= SEG_BLANK;
      an_q      <= 4'b1111;
      dp_q      <= 1'b1;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tl_q      <= tl_d;
      pre_q     <= pre_d;
      ref_q     <= ref_d;
      scan_q    <= scan_d;
      scan_on_q <= scan_on_d;
      blk_cnt_q <= blk_cnt_d;
      blink_q   <= blink_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
      pulse_q   <= pulse_d;
    end
  end

  assign seg          = seg_q;
  assign an           = an_q;
  assign dp           = dp_q;
  assign time_left    = tl_q;
  assign running      = (state_q == ST_RUNNING);
  assign expired      = (state_q == ST_EXPIRED);
  assign expire_pulse = pulse_q;

endmodule

// File: tb/tb_match_timer.sv
// Self-checking bench for match_timer (scaled timing parameters).
module tb_match_timer;

  localparam int CLK_HZ  = 100;
  localparam int MATCH   = 65;
  localparam int REFRESH = 4;
  localparam int FLASH   = 3;
  localparam int BLINK   = 20;

  localparam logic [6:0] B_DASH  = 7'h3F;
  localparam logic [6:0] B_BLANK = 7'h7F;
  localparam logic [6:0] B_D0    = 7'h40;
  localparam logic [6:0] B_D1    = 7'h79;
  localparam logic [6:0] B_D4    = 7'h19;

  logic        clock = 1'b0;
  logic        reset, start, start0, player, pause;
  logic [6:0]  seg, seg0;
  logic [3:0]  an, an0;
  logic        dp, dp0;
  logic [12:0] time_left, tl0;
  logic        running, expired, expire_pulse;
  logic        running0, expired0, pulse0;

  always #5 clock = ~clock;

  match_timer #(
    .CLK_HZ(CLK_HZ), .MATCH_SECONDS(MATCH), .REFRESH_DIV(REFRESH),
    .FLASH_SECONDS(FLASH), .BLINK_DIV(BLINK)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .player(player), .pause(pause),
    .seg(seg), .an(an), .dp(dp), .time_left(time_left), .running(running),
    .expired(expired), .expire_pulse(expire_pulse)
  );

  match_timer #(
    .CLK_HZ(CLK_HZ), .MATCH_SECONDS(0), .REFRESH_DIV(REFRESH),
    .FLASH_SECONDS(FLASH), .BLINK_DIV(BLINK)
  ) dut0 (
    .clock(clock), .reset(reset), .start(start0), .player(player), .pause(pause),
    .seg(seg0), .an(an0), .dp(dp0), .time_left(tl0), .running(running0),
    .expired(expired0), .expire_pulse(pulse0)
  );

  int checks   = 0;
  int failures = 0;
  int t   = 0;   // absolute edge count
  int cyc = 0;   // edges since last reset edge

  always @(posedge clock) begin
    t   <= t + 1;
    cyc <= reset ? 0 : cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_t(input int target);
    while (t < target) step(1);
  endtask

  function automatic logic [3:0] an_model(input int n);
    logic [3:0] one;
    int d;
    if (n < REFRESH) return 4'hF;
    d = (n / REFRESH - 1) % 4;
    one = 4'b0001 << d;
    return ~one;
  endfunction

  function automatic int blink_model(input int n);
    return (n / BLINK) % 2;
  endfunction

  // Scoreboard of expected time_left changes: {edge index, new value}.
  typedef struct {
    int          at;
    logic [12:0] val;
  } tl_ev_t;
  tl_ev_t      sb[$];
  logic [12:0] prev_tl = 13'd65;
  bit          mon_on  = 1'b0;
  int          pulse_cnt = 0;
  int          pulse_at  = -1;

  always @(negedge clock) begin
    if (mon_on) begin
      if (time_left !== prev_tl) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tl_unexpected: got %0d with no change pending (t=%0d)", time_left, t);
        end else begin
          tl_ev_t ev;
          ev = sb.pop_front();
          chk("tl_val", time_left, ev.val);
          chk("tl_at", t, ev.at);
        end
        prev_tl = time_left;
      end
      if (expire_pulse) begin
        pulse_cnt++;
        pulse_at = t;
      end
    end
  end

  // Display vectors: drive player, wait for the selected digit, compare seg/dp.
  typedef struct {
    logic       ply;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } vec_t;
  vec_t vecs[16];

  task automatic run_vecs(input int first, input int last, input string tag);
    int n;
    for (int i = first; i <= last; i++) begin
      player = vecs[i].ply;
      n = 0;
      do begin
        step(1);
        n++;
      end while (an !== vecs[i].an && n < 24);
      if (an !== vecs[i].an) begin
        checks++;
        failures++;
        $display("FAIL %s[%0d] scan timeout: an=%b wanted %b", tag, i, an, vecs[i].an);
      end else begin
        chk({tag, "_seg"}, seg, vecs[i].seg);
        chk({tag, "_dp"}, dp, vecs[i].dp);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish (t=%0d)", t);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, p, tick63, t3, t0, e1, z, np;
    int bl;
    vecs[0]  = '{1'b1, 4'b1110, B_DASH, 1'b1};
    vecs[1]  = '{1'b1, 4'b1101, B_DASH, 1'b1};
    vecs[2]  = '{1'b1, 4'b1011, B_DASH, 1'b1};
    vecs[3]  = '{1'b1, 4'b0111, B_DASH, 1'b0};
    vecs[4]  = '{1'b0, 4'b0111, B_DASH, 1'b1};
    vecs[5]  = '{1'b0, 4'b1011, B_DASH, 1'b1};
    vecs[6]  = '{1'b0, 4'b1110, B_D4,   1'b1};
    vecs[7]  = '{1'b0, 4'b1101, B_D0,   1'b1};
    vecs[8]  = '{1'b0, 4'b1011, B_D1,   1'b0};
    vecs[9]  = '{1'b0, 4'b0111, B_D0,   1'b1};
    vecs[10] = '{1'b0, 4'b1110, B_D0,   1'b1};
    vecs[11] = '{1'b0, 4'b1101, B_D0,   1'b1};
    vecs[12] = '{1'b0, 4'b1011, B_D0,   1'b0};
    vecs[13] = '{1'b0, 4'b0111, B_D0,   1'b1};
    vecs[14] = '{1'b1, 4'b0111, B_DASH, 1'b0};
    vecs[15] = '{1'b1, 4'b1110, B_DASH, 1'b1};

    reset = 1'b1; start = 1'b0; start0 = 1'b0; player = 1'b1; pause = 1'b0;
    step(3);
    chk("rst_seg", seg, B_BLANK);
    chk("rst_an", an, 4'hF);
    chk("rst_dp", dp, 1);
    chk("rst_tl", time_left, MATCH);
    chk("rst_running", running, 0);
    chk("rst_expired", expired, 0);
    chk("rst_pulse", expire_pulse, 0);
    mon_on = 1'b1;
    reset  = 1'b0;

    // Scan order from reset: nothing lit for one refresh period, then an[0] first.
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk("an_scan", an, an_model(cyc));
    end
    run_vecs(0, 3, "idle_p1");
    run_vecs(4, 5, "idle_p0");

    // Start: running next edge, first decrement CLK_HZ edges later.
    chk("pre_start_running", running, 0);
    start = 1'b1;
    e0 = t + 1;
    sb.push_back('{e0 + CLK_HZ, 13'd64});
    step(1);
    chk("start_running", running, 1);
    chk("start_expired", expired, 0);
    wait_t(e0 + CLK_HZ);
    chk("tl_64", time_left, 64);
    run_vecs(6, 9, "run_0104");

    // Pause with the prescaler at 50, hold 300 edges.
    wait_t(e0 + CLK_HZ + 50);
    pause = 1'b1;
    step(1);
    chk("pause_running", running, 0);
    while (t < e0 + CLK_HZ + 350) begin
      step(1);
      chk("paused_running", running, 0);
    end
    // One resume edge, then the remaining 50 prescaler counts.
    p = t;
    tick63 = p + 1 + CLK_HZ / 2;
    sb.push_back('{tick63, 13'd63});
    for (int v = 62; v >= 0; v--) sb.push_back('{tick63 + (63 - v) * CLK_HZ, 13'(v)});
    pause = 1'b0;
    step(1);
    chk("resume_running", running, 1);

    // Flash window: 3, 2, 1 seconds left.
    t3 = tick63 + 60 * CLK_HZ;
    t0 = tick63 + 63 * CLK_HZ;
    wait_t(t3);
    chk("tl_3", time_left, 3);
    while (t < t0) begin
      step(1);
      bl = blink_model(cyc - 1);
      chk("flash_an", an, an_model(cyc));
      if (bl == 1) begin
        chk("flash_blank", seg, B_BLANK);
        chk("flash_dp", dp, 1);
      end else begin
        chk("flash_shown", int'(seg != B_BLANK), 1);
      end
    end

    // Expiry on the 1 -> 0 tick.
    chk("exp_tl", time_left, 0);
    chk("exp_expired", expired, 1);
    chk("exp_pulse", expire_pulse, 1);
    chk("exp_running", running, 0);
    step(1);
    chk("exp_pulse_drop", expire_pulse, 0);
    chk("exp_hold", expired, 1);
    for (int i = 0; i < 40; i++) begin
      step(1);
      chk("exp_steady_seg", seg, B_D0);
      chk("exp_steady_dp", dp, (an_model(cyc) == 4'b1011) ? 0 : 1);
    end
    run_vecs(10, 13, "exp_0000");
    chk("pulse_count", pulse_cnt, 1);
    chk("pulse_at", pulse_at, t0);
    chk("exp_still", expired, 1);

    // Drop start in EXPIRED.
    start = 1'b0;
    sb.push_back('{t + 1, 13'd65});
    step(1);
    chk("idle_expired", expired, 0);
    chk("idle_running", running, 0);
    chk("idle_tl", time_left, MATCH);
    run_vecs(14, 15, "idle_again");

    // Reset in the middle of a running match.
    start = 1'b1;
    e1 = t + 1;
    sb.push_back('{e1 + CLK_HZ, 13'd64});
    wait_t(e1 + CLK_HZ + 50);
    chk("mid_running", running, 1);
    reset = 1'b1;
    start = 1'b0;
    sb.push_back('{t + 1, 13'd65});
    step(1);
    chk("mid_rst_seg", seg, B_BLANK);
    chk("mid_rst_an", an, 4'hF);
    chk("mid_rst_dp", dp, 1);
    chk("mid_rst_tl", time_left, MATCH);
    chk("mid_rst_running", running, 0);
    chk("mid_rst_expired", expired, 0);
    chk("mid_rst_pulse", expire_pulse, 0);
    reset = 1'b0;

    // Zero-length match goes straight to EXPIRED with one pulse.
    step(2);
    chk("zero_idle_expired", expired0, 0);
    start0 = 1'b1;
    z = t + 1;
    np = 0;
    step(1);
    chk("zero_expired", expired0, 1);
    chk("zero_pulse", pulse0, 1);
    chk("zero_running", running0, 0);
    chk("zero_tl", tl0, 0);
    chk("zero_edge", t, z);
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (pulse0) np++;
    end
    chk("zero_pulse_extra", np, 0);
    chk("zero_hold", expired0, 1);

    step(5);
    chk("sb_empty", sb.size(), 0);
    mon_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
